// File: rtl/riscv_defines.sv
// Shared definitions for the data-bus arbiter: FSM encoding and the
// read-data pattern returned when a response times out.
package riscv_defines;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port
// that was not granted most recently wins.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic [0:0] last_i,
    output logic       winner_o
);

    always_comb begin
        winner_o = 1'b0;
        if (req_i == 2'b11) begin
            winner_o = ~last_i[0];
        end else if (req_i[1]) begin
            winner_o = 1'b1;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-port arbiter onto a single-outstanding memory bus with a response timeout.
// state | meaning
// IDLE  | no transaction; pick a winner and register its request
// ADDR  | mem_req_o held with stable payload until mem_gnt_i
// RESP  | waiting for mem_rvalid_i or timeout, routed to the owner port
module data_bus_arbiter
    import riscv_defines::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req_i,
    input  logic [31:0] p0_addr_i,
    input  logic        p0_we_i,
    input  logic [3:0]  p0_be_i,
    input  logic [31:0] p0_wdata_i,
    output logic        p0_gnt_o,
    output logic        p0_rvalid_o,
    output logic        p0_err_o,
    input  logic        p1_req_i,
    input  logic [31:0] p1_addr_i,
    input  logic        p1_we_i,
    input  logic [3:0]  p1_be_i,
    input  logic [31:0] p1_wdata_i,
    output logic        p1_gnt_o,
    output logic        p1_rvalid_o,
    output logic        p1_err_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    arb_state_t  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;

    logic        winner;
    logic [1:0]  gnt, rvalid, err;
    logic [31:0] rdata;

    rr_arbiter_2 u_rr (
        .req_i    ({p1_req_i, p0_req_i}),
        .last_i   (last_q),
        .winner_o (winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        gnt         = 2'b00;
        rvalid      = 2'b00;
        err         = 2'b00;
        rdata       = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (p0_req_i || p1_req_i) begin
                    owner_d     = winner;
                    mem_req_d   = 1'b1;
                    mem_we_d    = winner ? p1_we_i    : p0_we_i;
                    mem_addr_d  = winner ? p1_addr_i  : p0_addr_i;
                    mem_wdata_d = winner ? p1_wdata_i : p0_wdata_i;
                    mem_be_d    = winner ? p1_be_i    : p0_be_i;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (mem_gnt_i) begin
                    gnt[owner_q] = 1'b1;
                    last_d       = owner_q;
                    cnt_d        = 8'd0;
                    mem_req_d    = 1'b0;
                    state_d      = RESP;
                end
            end
            RESP: begin
                rdata = mem_rdata_i;
                // A real response wins over a timeout landing in the same cycle.
                if (mem_rvalid_i) begin
                    rvalid[owner_q] = 1'b1;
                    state_d         = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    rvalid[owner_q] = 1'b1;
                    err[owner_q]    = 1'b1;
                    rdata           = ARB_TIMEOUT_RDATA;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign p0_gnt_o    = gnt[0];
    assign p1_gnt_o    = gnt[1];
    assign p0_rvalid_o = rvalid[0];
    assign p1_rvalid_o = rvalid[1];
    assign p0_err_o    = err[0];
    assign p1_err_o    = err[1];
    assign rdata_o     = rdata;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: single transfers, round-robin,
// stalled grant, timeout, reset mid-response and stray handshakes.
module tb_data_bus_arbiter;

    logic        clk, rst_n;
    logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
    logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
    logic [3:0]  p0_be_i, p1_be_i;
    logic        p0_gnt_o, p0_rvalid_o, p0_err_o, p1_gnt_o, p1_rvalid_o, p1_err_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [3:0]  mem_be_o;

    int n_checks = 0;
    int n_errors = 0;
    int gnt0_n = 0, gnt1_n = 0, rv0_n = 0, rv1_n = 0, excl_n = 0;

    data_bus_arbiter #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i),
        .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i),
        .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_err_o(p0_err_o),
        .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i),
        .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i),
        .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_err_o(p1_err_o),
        .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            gnt0_n += int'(p0_gnt_o);
            gnt1_n += int'(p1_gnt_o);
            rv0_n  += int'(p0_rvalid_o);
            rv1_n  += int'(p1_rvalid_o);
            if ((p0_gnt_o && p1_gnt_o) || (p0_rvalid_o && p1_rvalid_o)) excl_n++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] port_outs();
        return 32'({p1_gnt_o, p0_gnt_o, p1_err_o, p0_err_o, p1_rvalid_o, p0_rvalid_o});
    endfunction

    // Owner p0 read; no rvalid until the 64th RESP cycle (optionally there).
    task automatic run_timeout(input bit rv_at_last, input string tag);
        int early;
        early = 0;
        p0_req_i = 1'b1; p0_addr_i = 32'h0000_0080; p0_we_i = 1'b0;
        cyc();
        mem_gnt_i = 1'b1;
        #2 check_eq({tag, "_gnt"}, port_outs(), 32'b01_00_00);
        cyc();
        mem_gnt_i = 1'b0; p0_req_i = 1'b0;
        for (int c = 1; c < 64; c++) begin
            #2 if (p0_rvalid_o || p0_err_o || p1_rvalid_o) early++;
            cyc();
        end
        check_eq({tag, "_early"}, 32'(early), 32'd0);
        mem_rvalid_i = rv_at_last; mem_rdata_i = 32'h0BAD_F00D;
        #2;
        if (rv_at_last) begin
            check_eq({tag, "_outs"}, port_outs(), 32'b00_00_01);
            check_eq({tag, "_rdata"}, rdata_o, 32'h0BAD_F00D);
        end else begin
            check_eq({tag, "_outs"}, port_outs(), 32'b00_01_01);
            check_eq({tag, "_rdata"}, rdata_o, 32'hDEAD_BEEF);
        end
        cyc();
        mem_rvalid_i = 1'b0;
        #2 check_eq({tag, "_after"}, port_outs(), 32'd0);
    endtask

    int g0, g1, r0, r1, n;
    logic [1:0] exp_g;

    initial begin
        rst_n = 1'b0;
        p0_req_i = 0; p0_addr_i = 0; p0_we_i = 0; p0_be_i = 4'hF; p0_wdata_i = 0;
        p1_req_i = 0; p1_addr_i = 0; p1_we_i = 0; p1_be_i = 4'hF; p1_wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        repeat (3) cyc();
        check_eq("rst_mem", 32'({mem_req_o, mem_we_o, mem_be_o}), 32'd0);
        check_eq("rst_addr", mem_addr_o, 32'd0);
        check_eq("rst_ports", port_outs(), 32'd0);
        rst_n = 1'b1;

        // Single p0 read, grant in second ADDR cycle.
        g0 = gnt0_n; g1 = gnt1_n; r0 = rv0_n; r1 = rv1_n;
        cyc();
        p0_req_i = 1'b1; p0_addr_i = 32'h0000_0010;
        #2 check_eq("s1_idle_req", 32'(mem_req_o), 32'd0);
        cyc();
        #2 check_eq("s1_addr1_req", 32'(mem_req_o), 32'd1);
        check_eq("s1_addr", mem_addr_o, 32'h0000_0010);
        check_eq("s1_no_gnt", port_outs(), 32'd0);
        cyc();
        mem_gnt_i = 1'b1;
        #2 check_eq("s1_gnt", port_outs(), 32'b01_00_00);
        cyc();
        mem_gnt_i = 1'b0; p0_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        #2 check_eq("s1_rvalid", port_outs(), 32'b00_00_01);
        check_eq("s1_rdata", rdata_o, 32'h1234_5678);
        check_eq("s1_req_low", 32'(mem_req_o), 32'd0);
        cyc();
        mem_rvalid_i = 1'b0;
        #2 check_eq("s1_idle", port_outs(), 32'd0);
        cyc();
        check_eq("s1_pulses", 32'({8'(gnt0_n - g0), 8'(rv0_n - r0), 8'(gnt1_n - g1), 8'(rv1_n - r1)}),
                 32'h0101_0000);

        // Both ports requesting continuously; fresh reset so p0 is favoured.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        p0_req_i = 1'b1; p0_addr_i = 32'h0000_0100;
        p1_req_i = 1'b1; p1_addr_i = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!mem_req_o && n < 10) begin
                cyc();
                n++;
            end
            check_eq("s2_req_seen", 32'(mem_req_o), 32'd1);
            if (i > 0) check_eq("s2_turnaround", 32'(n), 32'd1);
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            mem_gnt_i = 1'b1;
            #2 check_eq("s2_gnt", 32'({p1_gnt_o, p0_gnt_o}), 32'(exp_g));
            check_eq("s2_addr", mem_addr_o, (i % 2 == 0) ? 32'h100 : 32'h200);
            cyc();
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
            cyc();
            mem_rvalid_i = 1'b0;
        end
        p0_req_i = 1'b0; p1_req_i = 1'b0;
        cyc();

        // p1 write held in ADDR for 5 cycles; stray rvalid and dropped req ignored.
        g1 = gnt1_n;
        p1_req_i = 1'b1; p1_addr_i = 32'h0000_0040; p1_we_i = 1'b1;
        p1_be_i = 4'b1100; p1_wdata_i = 32'hAABB_0000;
        cyc();
        for (int k = 0; k < 5; k++) begin
            mem_rvalid_i = (k == 2);
            if (k == 3) begin
                p1_req_i = 1'b0; p1_addr_i = 32'hFFF0; p1_wdata_i = 32'h0; p1_we_i = 1'b0;
            end
            #2 check_eq("s3_addr", mem_addr_o, 32'h0000_0040);
            check_eq("s3_wdata", mem_wdata_o, 32'hAABB_0000);
            check_eq("s3_ctl", 32'({mem_req_o, mem_we_o, mem_be_o}), 32'b1_1_1100);
            check_eq("s3_quiet", port_outs(), 32'd0);
            cyc();
        end
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        #2 check_eq("s3_gnt", port_outs(), 32'b10_00_00);
        cyc();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
        #2 check_eq("s3_rvalid", port_outs(), 32'b00_00_10);
        cyc();
        mem_rvalid_i = 1'b0;
        cyc();
        check_eq("s3_one_gnt", 32'(gnt1_n - g1), 32'd1);

        // Timeout, then a normal p1 transfer.
        run_timeout(1'b0, "s4");
        p1_req_i = 1'b1; p1_addr_i = 32'h0000_0300; p1_we_i = 1'b0;
        cyc();
        mem_gnt_i = 1'b1;
        #2 check_eq("s4_next_gnt", port_outs(), 32'b10_00_00);
        cyc();
        mem_gnt_i = 1'b0; p1_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_0001;
        #2 check_eq("s4_next_rv", port_outs(), 32'b00_00_10);
        check_eq("s4_next_rdata", rdata_o, 32'hCAFE_0001);
        cyc();
        mem_rvalid_i = 1'b0;

        // rvalid coinciding with the timeout is a normal response.
        run_timeout(1'b1, "s4b");

        // Reset during RESP.
        p1_req_i = 1'b1; p1_addr_i = 32'h0000_0500;
        cyc();
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0; p1_req_i = 1'b0;
        rst_n = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        #1 check_eq("s5_rst_ports", port_outs(), 32'd0);
        check_eq("s5_rst_rdata", rdata_o, 32'd0);
        check_eq("s5_rst_mem", 32'({mem_req_o, mem_we_o, mem_be_o}), 32'd0);
        check_eq("s5_rst_addr", mem_addr_o, 32'd0);
        cyc();
        rst_n = 1'b1;
        #2 check_eq("s5_late_rv", port_outs(), 32'd0);
        cyc();
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        #2 check_eq("s5_stray_gnt", port_outs(), 32'd0);
        cyc();
        mem_gnt_i = 1'b0; p1_req_i = 1'b1; p1_addr_i = 32'h0000_0600;
        #2 check_eq("s5_idle_req", 32'(mem_req_o), 32'd0);
        cyc();
        #2 check_eq("s5_addr", mem_addr_o, 32'h0000_0600);
        mem_gnt_i = 1'b1;
        #2 check_eq("s5_gnt", port_outs(), 32'b10_00_00);
        cyc();
        mem_gnt_i = 1'b0; p1_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0600;
        #2 check_eq("s5_rv", port_outs(), 32'b00_00_10);
        cyc();
        mem_rvalid_i = 1'b0;

        // Stray rvalid in IDLE.
        cyc();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        #2 check_eq("s6_stray_rv", port_outs(), 32'd0);
        check_eq("s6_rdata", rdata_o, 32'd0);
        cyc();
        mem_rvalid_i = 1'b0;
        cyc();

        check_eq("excl", 32'(excl_n), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum cycles RESP waits for mem_rvalid_i; legal range 2..255.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 p0_req_i / p1_req_i  input  1  request from port 0 (core LSU) / port 1 (secondary master); held high until matching gnt.
REQ-005 p0_addr_i / p1_addr_i  input  32  word address, already aligned by requester.
REQ-006 p0_we_i / p1_we_i  input  1  1 = write, 0 = read.
REQ-007 p0_be_i / p1_be_i  input  4  byte enables.
REQ-008 p0_wdata_i / p1_wdata_i  input  32  write data, lane-aligned.
REQ-009 p0_gnt_o / p1_gnt_o  output  1  request accepted by memory (one-cycle pulse).
REQ-010 p0_rvalid_o / p1_rvalid_o  output  1  response valid for that port (one-cycle pulse).
REQ-011 p0_err_o / p1_err_o  output  1  response timed out; pulses together with that port's rvalid.
REQ-012 rdata_o  output  32  shared read-data bus, qualified only by pN_rvalid_o.
REQ-013 mem_req_o, mem_we_o  output  1 each  memory request, write enable.
REQ-014 mem_addr_o, mem_wdata_o  output  32 each; mem_be_o  output  4.
REQ-015 mem_gnt_i, mem_rvalid_i  input  1 each; mem_rdata_i  input  32.

Function
REQ-016 FSM states SHALL be IDLE, ADDR, RESP; at most one outstanding transaction.
REQ-017 IDLE, no request: stay IDLE; mem_req_o = 0.
REQ-018 IDLE, one or both requests: winner chosen round-robin. Single requester wins. If both request, the port not most recently granted wins. After reset, port 0 has priority.
REQ-019 In IDLE, winner's addr/we/be/wdata SHALL be registered into mem_* outputs; owner register := winner; next state ADDR. mem_req_o rises exactly one cycle after pN_req_i is first sampled high.
REQ-020 In ADDR, mem_req_o = 1 and mem_* SHALL hold stable until mem_gnt_i = 1.
REQ-021 In the mem_gnt_i cycle, p<owner>_gnt_o = 1 combinationally, the other gnt = 0, last-granted := owner, and the next state is RESP. mem_req_o SHALL be 0 from the next cycle.
REQ-022 In RESP, p<owner>_rvalid_o = mem_rvalid_i; rdata_o = mem_rdata_i. On mem_rvalid_i, next state is IDLE.
REQ-023 Timeout counter SHALL clear on entry to RESP and increment each RESP cycle without rvalid. When it reaches TIMEOUT_CYCLES-1 without rvalid: p<owner>_rvalid_o = 1, p<owner>_err_o = 1, rdata_o = 32'hDEAD_BEEF, next state IDLE.
REQ-024 rvalid arriving in the same cycle the timeout fires SHALL be treated as a normal response (err = 0).
REQ-025 mem_gnt_i in IDLE/RESP and mem_rvalid_i in IDLE/ADDR SHALL be ignored; no port output changes.
REQ-026 Minimum turnaround: gnt in cycle N, rvalid in N+1, return to IDLE in N+2, next mem_req_o in N+3.
REQ-027 A requester dropping pN_req_i before gnt (protocol violation) SHALL NOT abort ADDR; the transaction completes.
REQ-028 pN_gnt_o and pN_rvalid_o SHALL never be high for both ports in the same cycle.

Reset
REQ-029 On rst_n low, regardless of state: FSM to IDLE, owner = 0, last-granted = port 1 (port 0 favoured), counter = 0, all mem_* outputs = 0.
REQ-030 While in reset, all pN_gnt_o/pN_rvalid_o/pN_err_o = 0 and rdata_o = 0. An in-flight transaction is dropped with no response.

Structure
REQ-031 Enum arb_state_t {IDLE, ADDR, RESP} and constant ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF SHALL reside in riscv_defines.
REQ-032 Round-robin choice SHALL be a sub-module rr_arbiter_2: inputs req[1:0], last[0:0]; output winner.

Verification
REQ-033 Directed scenarios:
- p0 read addr 0x0000_0010; mem_gnt_i in 2nd ADDR cycle, rvalid next cycle with 0x1234_5678 -> p0_gnt_o one pulse; p0_rvalid_o one pulse; rdata_o = 0x1234_5678; p1 outputs stay 0.
- p0 and p1 both request continuously -> grants alternate p0, p1, p0, p1; first grant p0 after reset.
- p1 write be = 4'b1100, wdata = 0xAABB_0000, mem_gnt_i delayed 5 cycles -> mem_* stable all 5 cycles; single p1_gnt_o.
- No rvalid after gnt, TIMEOUT_CYCLES = 64 -> on 64th RESP cycle p<owner>_rvalid_o = p<owner>_err_o = 1, rdata_o = 0xDEAD_BEEF; next request accepted.
- rst_n asserted during RESP -> outputs 0 immediately; late rvalid after release ignored; next p1-only request granted normally.
- Stray mem_rvalid_i in IDLE -> no pN_rvalid_o.
